// File: rtl/mul8u_acc_pkg.sv
// rtl/mul8u_acc_pkg.sv - Shared types and constants for the multiplier dot-product accumulator.
package mul8u_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int PROD_W = 16;

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/mul8u_sat_add.sv
// rtl/mul8u_sat_add.sv - Combinational unsigned saturating adder.
module mul8u_sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b};
  assign ovf    = w_full[W];
  assign sum    = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule

// File: rtl/mul8u_dot_acc.sv
// rtl/mul8u_dot_acc.sv - Accumulates a product stream into one saturated dot-product per vector.
// MUL8U_BIAS_COMP_EN: adds BIAS to every accepted product before accumulation.
module mul8u_dot_acc
  import mul8u_acc_pkg::*;
#(
  parameter  int LEN   = 16,
  parameter  int ACC_W = 24,
  parameter  int BIAS  = 6,
  localparam int CW    = cnt_width(LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CW-1:0]     out_cnt,
  output logic              out_ovf
);

`ifdef MUL8U_BIAS_COMP_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif
  localparam logic [ACC_W:0] TERM_ADD = BIAS_EN ? (ACC_W+1)'(BIAS) : '0;

  state_t            r_state, w_state_nxt;
  logic [ACC_W-1:0]  r_acc, r_out_acc, w_acc_base, w_add_sum, w_acc_nxt;
  logic [ACC_W:0]    w_term_wide;
  logic [CW-1:0]     r_cnt, r_out_cnt, w_cnt_base, w_cnt_nxt;
  logic              r_ovf, r_out_ovf, r_out_valid;
  logic              w_add_ovf, w_ovf_nxt, w_accept, w_term_beat, w_take;

  assign in_ready  = (r_state != HOLD);
  assign w_accept  = in_valid & in_ready;
  assign w_take    = r_out_valid & out_ready;

  // The biased term can itself exceed ACC_W bits when ACC_W is narrow; that also saturates.
  assign w_term_wide = (ACC_W+1)'(in_prod) + TERM_ADD;
  assign w_acc_base  = (r_state == IDLE) ? '0 : r_acc;
  assign w_cnt_base  = (r_state == IDLE) ? '0 : r_cnt;

  mul8u_sat_add #(.W(ACC_W)) u_sat_add (
    .a   (w_acc_base),
    .b   (w_term_wide[ACC_W-1:0]),
    .sum (w_add_sum),
    .ovf (w_add_ovf)
  );

  assign w_acc_nxt   = w_term_wide[ACC_W] ? {ACC_W{1'b1}} : w_add_sum;
  assign w_ovf_nxt   = ((r_state == IDLE) ? 1'b0 : r_ovf) | w_add_ovf | w_term_wide[ACC_W];
  assign w_cnt_nxt   = w_cnt_base + 1'b1;
  assign w_term_beat = in_last | (w_cnt_nxt == CW'(LEN));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_term_beat ? HOLD : ACCUM;
      ACCUM:   if (w_accept && w_term_beat) w_state_nxt = HOLD;
      HOLD:    if (w_take) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_cnt   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_nxt;
        r_ovf <= w_ovf_nxt;
        if (w_term_beat) begin
          r_out_valid <= 1'b1;
          r_out_acc   <= w_acc_nxt;
          r_out_cnt   <= w_cnt_nxt;
          r_out_ovf   <= w_ovf_nxt;
        end
      end
      if (w_take) begin
        r_out_valid <= 1'b0;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovf       <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_cnt   = r_out_cnt;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mul8u_dot_acc.sv
// tb/tb_mul8u_dot_acc.sv - Scoreboard bench for mul8u_dot_acc (ACC_W=24 and ACC_W=17 instances).
module tb_mul8u_dot_acc;

`ifdef MUL8U_BIAS_COMP_EN
  localparam longint BI = 6;
`else
  localparam longint BI = 0;
`endif

  typedef struct {
    longint acc;
    int     cnt;
    bit     ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf;
  logic [15:0] a_in_prod;
  logic [23:0] a_out_acc;
  logic [4:0]  a_out_cnt;
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
  logic [15:0] b_in_prod;
  logic [16:0] b_out_acc;
  logic [4:0]  b_out_cnt;

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   bad   = 0;

  mul8u_dot_acc u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_prod(a_in_prod), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_acc(a_out_acc), .out_cnt(a_out_cnt), .out_ovf(a_out_ovf)
  );

  mul8u_dot_acc #(.ACC_W(17)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_acc(b_out_acc), .out_cnt(b_out_cnt), .out_ovf(b_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input bit sel, input longint acc, input int cnt, input bit ovf);
    exp_t e;
    e.acc = acc;
    e.cnt = cnt;
    e.ovf = ovf;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input bit sel, input logic [15:0] prod, input bit last);
    bit ok, rdy;
    ok = 1'b0;
    if (sel) begin b_in_valid = 1'b1; b_in_prod = prod; b_in_last = last; end
    else     begin a_in_valid = 1'b1; a_in_prod = prod; a_in_last = last; end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = sel ? b_in_ready : a_in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (sel) begin b_in_valid = 1'b0; b_in_last = 1'b0; end
    else     begin a_in_valid = 1'b0; a_in_last = 1'b0; end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && a_out_valid && a_out_ready) begin
      if (q_a.size() == 0) chk("a_unexpected_result", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_acc", longint'(a_out_acc), e.acc);
        chk("a_cnt", longint'(a_out_cnt), longint'(e.cnt));
        chk("a_ovf", longint'(a_out_ovf), longint'(e.ovf));
      end
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      if (q_b.size() == 0) chk("b_unexpected_result", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("b_acc", longint'(b_out_acc), e.acc);
        chk("b_cnt", longint'(b_out_cnt), longint'(e.cnt));
        chk("b_ovf", longint'(b_out_ovf), longint'(e.ovf));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b1; a_in_prod = 16'd500; a_in_last = 1'b1; a_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_prod = 16'd500; b_in_last = 1'b1; b_out_ready = 1'b1;

    // Reset held with valid beats offered
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", longint'(a_out_valid), 0);
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1;
    a_in_valid = 1'b0; a_in_last = 1'b0;
    b_in_valid = 1'b0; b_in_last = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", longint'(a_in_ready), 1);
    chk("rst_out_acc", longint'(a_out_acc), 0);
    chk("rst_out_cnt", longint'(a_out_cnt), 0);
    chk("rst_out_ovf", longint'(a_out_ovf), 0);
    chk("rst_b_out_valid", longint'(b_out_valid), 0);
    @(posedge clk);
    #1;

    // Three-beat vector
    push(1'b0, 600 + 3 * BI, 3, 1'b0);
    send(1'b0, 16'd100, 1'b0);
    send(1'b0, 16'd200, 1'b0);
    chk("v3_no_early_valid", longint'(a_out_valid), 0);
    send(1'b0, 16'd300, 1'b1);
    chk("v3_latency", longint'(a_out_valid), 1);

    // LEN beats without in_last auto-terminate
    push(1'b0, 16 * (65025 + BI), 16, 1'b0);
    for (int i = 0; i < 16; i++) send(1'b0, 16'd65025, 1'b0);
    chk("len_auto_term", longint'(a_out_valid), 1);
    chk("len_in_ready", longint'(a_in_ready), 0);

    // Saturation in the 17-bit instance
    push(1'b1, 131071, 3, 1'b1);
    send(1'b1, 16'd65535, 1'b0);
    send(1'b1, 16'd65535, 1'b0);
    send(1'b1, 16'd10, 1'b1);

    // Result held while downstream stalls
    repeat (2) @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    push(1'b0, 110 + 2 * BI, 2, 1'b0);
    send(1'b0, 16'd50, 1'b0);
    send(1'b0, 16'd60, 1'b1);
    a_in_valid = 1'b1; a_in_prod = 16'd999; a_in_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", longint'(a_out_valid), 1);
      chk("hold_out_acc", longint'(a_out_acc), 110 + 2 * BI);
      chk("hold_out_cnt", longint'(a_out_cnt), 2);
      chk("hold_in_ready", longint'(a_in_ready), 0);
      @(posedge clk);
      #1;
    end
    a_in_valid = 1'b0; a_in_last = 1'b0;
    a_out_ready = 1'b1;
    push(1'b0, 7 + BI, 1, 1'b0);
    send(1'b0, 16'd7, 1'b1);

    // Reset mid-vector discards the partial sum
    repeat (2) @(posedge clk);
    #1;
    send(1'b0, 16'd1, 1'b0);
    send(1'b0, 16'd2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_out_valid", longint'(a_out_valid), 0);
    end
    @(posedge clk);
    #1;
    push(1'b0, 2 + 2 * BI, 2, 1'b0);
    send(1'b0, 16'd1, 1'b0);
    send(1'b0, 16'd1, 1'b1);

    for (int i = 0; i < 50; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      @(posedge clk);
    end
    chk("pending_results", longint'(q_a.size() + q_b.size()), 0);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
